dht11_ctrl: RTL
===============

// Module: dht11_ctrl
// PURPOSE
//  Sequences one complete DHT11 single-wire transaction: start pulse, sensor response, 40-bit frame, checksum.
//  Timebase is the 1 us tick from the clock_set/clock_usec chain; all durations are counted in those ticks.
//  Sits between the shared timebase and the AXI register wrapper of the DHT11 IP.
//  Presents humidity/temperature integer bytes plus valid and error status.
// PARAMETERS
//  START_LOW_US   18000  host low-drive time of the start pulse, in us ticks
//  TIMEOUT_US     200    max ticks any single wait state may last before error
//  BIT_THRESH_US  50     high-phase length >= this decodes as 1, < decodes as 0
//  POLL_PERIOD_MS 2000   auto-poll interval (used only with DHT11_AUTO_POLL_EN)
// PORTS
//  clk          in     1  system clock
//  reset_p      in     1  asynchronous reset, active-high
//  clk_usec     in     1  one-clk-wide pulse every 1 us
//  start        in     1  one-clk pulse requesting a read
//  dht11_data   inout  1  open-drain bus: driven 0 or 'z', never 1
//  humidity     out    8  integer RH byte of last good frame
//  temperature  out    8  integer degC byte of last good frame
//  valid        out    1  one-clk pulse, frame accepted
//  busy         out    1  high from accepted start until IDLE is re-entered
//  err_code     out    2  00 none, 01 timeout, 10 checksum; holds until next start
// BEHAVIOUR
//  Reset: humidity=0, temperature=0, valid=0, busy=0, err_code=00, bus released ('z'), state IDLE.
//  Bus input passes through a 2-FF synchronizer. Edges are detected on the synchronized value.
//  One tick counter (16 bit) clears on every state change and increments only on clk_usec.
//  States:
//   IDLE:  start=1 -> START_LOW, busy=1, err_code=00. start while busy is ignored.
//   START_LOW:  drive 0; cnt==START_LOW_US-1 on tick -> RELEASE.
//   RELEASE:  'z'; falling edge -> RESP_LOW.
//   RESP_LOW:  rising edge -> RESP_HIGH.
//   RESP_HIGH:  falling edge -> BIT_LOW, bit index=0.
//   BIT_LOW:  rising edge -> BIT_HIGH.
//   BIT_HIGH:  on falling edge, shift (cnt>=BIT_THRESH_US) MSB-first into 40-bit reg.
//              If index==39 -> CHECK, else index+1 -> BIT_LOW.
//   CHECK (1 clk):  (b0+b1+b2+b3) mod 256 == b4 -> load humidity=b0, temperature=b2, valid=1.
//                   Otherwise err_code=10 and outputs hold old values. Then -> IDLE.
//  Timeout: in RELEASE..BIT_HIGH, cnt reaching TIMEOUT_US -> err_code=01, release bus, -> IDLE. No output update.
//  Edge and tick in the same clk: the edge takes priority; the counter clears.
//  Latency: valid asserts 2 clk after the synchronized 40th falling edge (sync + CHECK).
//  Reset mid-transaction: bus released immediately (asynchronously); partial frame discarded.
//  busy drops in the same cycle valid/err_code is updated.
//  Decimal bytes b1/b3 are ignored (DHT11 reports 0).
// CONFIGURATION
//  DHT11_AUTO_POLL_EN defined:
//   - An internal ms counter (1000 ticks per ms) issues an internal start every POLL_PERIOD_MS.
//   - The internal start is ORed with the start port. The first auto start fires POLL_PERIOD_MS after reset.
//   - A poll due while busy is deferred until IDLE.
//  DHT11_AUTO_POLL_EN undefined: reads happen only on the start port; no poll counter is synthesized.
// STRUCTURE
//  Shared package dht11_pkg holds:
//   - state encoding (IDLE..CHECK, 3-bit)
//   - ERR_NONE / ERR_TIMEOUT / ERR_CKSUM codes
//   - frame width 40
//  One sub-module: dht11_line_sync (2-FF synchronizer plus pos/neg edge pulses, same style as edge_detector_n).
//  FSM, counter, shifter and checksum stay in dht11_ctrl.
// TESTING
//  1. Sensor model sends 0x37,0x00,0x19,0x00,0x50
//     -> valid pulse; humidity=55, temperature=25; err_code=00.
//  2. Same frame with checksum byte 0x51
//     -> no valid; err_code=10; humidity/temperature keep values from test 1.
//  3. Sensor never answers after release
//     -> err_code=01 at 200 us after RELEASE entry; bus 'z'; busy=0.
//  4. Bit high phases of 26 us and 70 us
//     -> decoded 0 and 1 respectively; 49 us -> 0; 50 us -> 1.
//  5. reset_p pulsed 5 ms into START_LOW
//     -> bus 'z' the same cycle; all outputs at reset values; a following start works.
//  6. Second start pulse during busy
//     -> ignored.
//     With DHT11_AUTO_POLL_EN and POLL_PERIOD_MS=3: starts at 3 ms, then every 3 ms.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 controller: FSM state encoding, error codes,
// frame width and the frame checksum helper.
package dht11_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START_LOW = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RESP_LOW  = 3'd3,
      ST_RESP_HIGH = 3'd4,
      ST_BIT_LOW   = 3'd5,
      ST_BIT_HIGH  = 3'd6,
      ST_CHECK     = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_CKSUM   = 2'b10;

   localparam int FRAME_W = 40;

   // Byte 4 must equal the 8-bit wrapping sum of bytes 0..3.
   function automatic logic cksum_ok(input logic [FRAME_W-1:0] frame);
      logic [7:0] sum;
      sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return sum == frame[7:0];
   endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the DHT11 bus with single-clock rise/fall pulses
// taken from the synchronized level.
module dht11_line_sync
   import dht11_pkg::*;
(
   input  logic clk,
   input  logic reset_p,
   input  logic line,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_reg;
   logic       prev_reg;

   // Reset to the idle-high bus level so leaving reset produces no edge.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         sync_reg <= 2'b11;
         prev_reg <= 1'b1;
      end else begin
         sync_reg <= {sync_reg[0], line};
         prev_reg <= sync_reg[1];
      end
   end

   assign rise = sync_reg[1] & ~prev_reg;
   assign fall = ~sync_reg[1] & prev_reg;

endmodule

// File: rtl/dht11_ctrl.sv
// DHT11 single-wire transaction sequencer: start pulse, response, 40-bit frame, checksum.
// Optional periodic self-triggering is enabled with `define DHT11_AUTO_POLL_EN.
module dht11_ctrl
   import dht11_pkg::*;
#(
   parameter int START_LOW_US   = 18000,
   parameter int TIMEOUT_US     = 200,
   parameter int BIT_THRESH_US  = 50,
   parameter int POLL_PERIOD_MS = 2000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       clk_usec,
   input  logic       start,
   inout  wire        dht11_data,
   output logic [7:0] humidity,
   output logic [7:0] temperature,
   output logic       valid,
   output logic       busy,
   output logic [1:0] err_code
);

   localparam logic [15:0] START_LAST   = 16'(START_LOW_US - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
   localparam logic [15:0] BIT_THRESH   = 16'(BIT_THRESH_US);

   state_t               state_reg;
   logic [15:0]          cnt_reg;
   logic [5:0]           bit_idx_reg;
   logic [FRAME_W-1:0]   frame_reg;
   logic                 drive_low_reg;
   logic                 line_rise;
   logic                 line_fall;
   logic                 start_req;
   logic                 timeout_hit;

   assign dht11_data = drive_low_reg ? 1'b0 : 1'bz;

   dht11_line_sync u_line_sync (
      .clk     (clk),
      .reset_p (reset_p),
      .line    (dht11_data),
      .rise    (line_rise),
      .fall    (line_fall)
   );

`ifdef DHT11_AUTO_POLL_EN
   logic [9:0]  us_cnt_reg;
   logic [15:0] ms_cnt_reg;
   logic        poll_pend_reg;

   // A due poll stays pending until the FSM is back in IDLE to consume it.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         us_cnt_reg    <= '0;
         ms_cnt_reg    <= '0;
         poll_pend_reg <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE && poll_pend_reg)
            poll_pend_reg <= 1'b0;
         if (clk_usec) begin
            if (us_cnt_reg == 10'd999) begin
               us_cnt_reg <= '0;
               if (ms_cnt_reg == 16'(POLL_PERIOD_MS - 1)) begin
                  ms_cnt_reg    <= '0;
                  poll_pend_reg <= 1'b1;
               end else begin
                  ms_cnt_reg <= ms_cnt_reg + 16'd1;
               end
            end else begin
               us_cnt_reg <= us_cnt_reg + 10'd1;
            end
         end
      end
   end

   assign start_req = start | poll_pend_reg;
`else
   assign start_req = start;
`endif

   assign timeout_hit = clk_usec && (cnt_reg == TIMEOUT_LAST);

   // Every state change clears cnt_reg; those assignments override the tick increment.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         frame_reg     <= '0;
         drive_low_reg <= 1'b0;
         humidity      <= '0;
         temperature   <= '0;
         valid         <= 1'b0;
         busy          <= 1'b0;
         err_code      <= ERR_NONE;
      end else begin
         valid <= 1'b0;
         if (clk_usec)
            cnt_reg <= cnt_reg + 16'd1;

         case (state_reg)
            ST_IDLE: begin
               if (start_req) begin
                  state_reg     <= ST_START_LOW;
                  drive_low_reg <= 1'b1;
                  busy          <= 1'b1;
                  err_code      <= ERR_NONE;
                  cnt_reg       <= '0;
               end
            end
            ST_START_LOW: begin
               if (clk_usec && cnt_reg == START_LAST) begin
                  state_reg     <= ST_RELEASE;
                  drive_low_reg <= 1'b0;
                  cnt_reg       <= '0;
               end
            end
            ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH: begin
               // Waiting on the sensor: the expected edge wins over a same-cycle timeout.
               if ((state_reg == ST_RELEASE   && line_fall) ||
                   (state_reg == ST_RESP_LOW  && line_rise) ||
                   (state_reg == ST_RESP_HIGH && line_fall) ||
                   (state_reg == ST_BIT_LOW   && line_rise) ||
                   (state_reg == ST_BIT_HIGH  && line_fall)) begin
                  cnt_reg <= '0;
                  case (state_reg)
                     ST_RELEASE:   state_reg <= ST_RESP_LOW;
                     ST_RESP_LOW:  state_reg <= ST_RESP_HIGH;
                     ST_RESP_HIGH: begin
                        state_reg   <= ST_BIT_LOW;
                        bit_idx_reg <= '0;
                     end
                     ST_BIT_LOW:   state_reg <= ST_BIT_HIGH;
                     default: begin
                        frame_reg <= {frame_reg[FRAME_W-2:0], (cnt_reg >= BIT_THRESH)};
                        if (bit_idx_reg == 6'(FRAME_W - 1)) begin
                           state_reg <= ST_CHECK;
                        end else begin
                           bit_idx_reg <= bit_idx_reg + 6'd1;
                           state_reg   <= ST_BIT_LOW;
                        end
                     end
                  endcase
               end else if (timeout_hit) begin
                  state_reg     <= ST_IDLE;
                  drive_low_reg <= 1'b0;
                  busy          <= 1'b0;
                  err_code      <= ERR_TIMEOUT;
                  cnt_reg       <= '0;
               end
            end
            ST_CHECK: begin
               if (cksum_ok(frame_reg)) begin
                  humidity    <= frame_reg[39:32];
                  temperature <= frame_reg[23:16];
                  valid       <= 1'b1;
               end else begin
                  err_code <= ERR_CKSUM;
               end
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
